bg_ctrl: RTL and testbench

BG_CTRL -- requirements
Module: bg_ctrl

---
 rtl/bg_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_bg_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_ctrl.sv
// bg_ctrl -- bandgap trim loop controller.
//
// Sequences the analog front end through power-up, comparator zeroing and a
// repeating two-phase (diode A / diode B) measurement loop. At the end of
// every COMPARE window the synchronized comparator result, corrected for the
// current chop polarity, steps the fine IDAC code up or down by one. A lock
// counter tracks consecutive alternating decisions (dithering around the
// trip point) and raises `locked` once LOCK_COUNT alternations are seen.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   enable              level-sensitive run request
//   idacCoarseCfg       coarse IDAC code, registered onto idacCoarse
//   resStableCfg        resistor select, registered onto resStableSelect
//   cmpo                comparator output (asynchronous to clk)
//   pwrup               analog power-up
//   idacFine            fine IDAC code driven by the loop
//   idacCoarse          registered idacCoarseCfg
//   idacOutSelect_n     active-low IDAC output enables
//   diodeSelect         diode array enables
//   resStableSelect     registered resStableCfg
//   resPtatEnable_n     active-low PTAT resistor enable
//   c1, c2              cap-cell switches {CA, CB}
//   cmpZeroOffset       comparator auto-zero
//   cmpSwapInput        comparator input swap (chop bit)
//   busy, locked        status
module bg_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int CMP_CYC    = 4,
  parameter int LOCK_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] idacCoarseCfg,
  input  logic       resStableCfg,
  input  logic       cmpo,
  output logic       pwrup,
  output logic [7:0] idacFine,
  output logic [7:0] idacCoarse,
  output logic [3:0] idacOutSelect_n,
  output logic [7:0] diodeSelect,
  output logic       resStableSelect,
  output logic       resPtatEnable_n,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic       cmpZeroOffset,
  output logic       cmpSwapInput,
  output logic       busy,
  output logic       locked
);

  localparam int         CNT_MAX  = (SETTLE_CYC > CMP_CYC) ? SETTLE_CYC : CMP_CYC;
  localparam int         CW       = $clog2(CNT_MAX + 1);
  localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PWRUP, ST_ZERO, ST_SAMPLE_A, ST_HOLD_A,
    ST_SAMPLE_B, ST_HOLD_B, ST_COMPARE, ST_UPDATE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    sync_reg;
  logic          chop_reg;
  logic [7:0]    fine_reg;
  logic [3:0]    lock_cnt_reg, lock_cnt_next;
  logic          prev_up_reg, prev_valid_reg;
  logic          locked_reg;
  logic          cmp_s, abort, cmp_done, up, blocked;

  // Number of cycles to spend in a state, minus one (the counter reload value).
  function automatic logic [CW-1:0] hold_len(input state_t s);
    case (s)
      ST_PWRUP, ST_SAMPLE_A, ST_SAMPLE_B: hold_len = CW'(SETTLE_CYC - 1);
      ST_ZERO, ST_COMPARE:                hold_len = CW'(CMP_CYC - 1);
      default:                            hold_len = '0;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      ST_PWRUP:    succ = ST_ZERO;
      ST_ZERO:     succ = ST_SAMPLE_A;
      ST_SAMPLE_A: succ = ST_HOLD_A;
      ST_HOLD_A:   succ = ST_SAMPLE_B;
      ST_SAMPLE_B: succ = ST_HOLD_B;
      ST_HOLD_B:   succ = ST_COMPARE;
      ST_COMPARE:  succ = ST_UPDATE;
      ST_UPDATE:   succ = ST_SAMPLE_A;
      default:     succ = ST_IDLE;
    endcase
  endfunction

  assign cmp_s    = sync_reg[1];
  assign abort    = (state_reg != ST_IDLE) && !enable;
  assign cmp_done = (state_reg == ST_COMPARE) && (cnt_reg == '0) && !abort;
  assign up       = cmp_s ^ chop_reg;
  // A step that would run past either end of the code range is blocked.
  assign blocked  = up ? (fine_reg == 8'hFF) : (fine_reg == 8'h00);

  always_comb begin
    state_next = state_reg;
    if (abort)
      state_next = ST_IDLE;
    else if (state_reg == ST_IDLE) begin
      if (enable)
        state_next = ST_PWRUP;
    end else if (cnt_reg == '0)
      state_next = succ(state_reg);

    // One shared timer: reload on every state entry, otherwise count down.
    if (state_next != state_reg)
      cnt_next = hold_len(state_next);
    else if (cnt_reg != '0)
      cnt_next = cnt_reg - 1'b1;
    else
      cnt_next = cnt_reg;
  end

  // Blocked steps and repeated directions both break the alternation run;
  // the very first decision after start has nothing to compare against.
  always_comb begin
    lock_cnt_next = '0;
    if (prev_valid_reg && !blocked && (up != prev_up_reg))
      lock_cnt_next = (lock_cnt_reg >= LOCK_MAX) ? LOCK_MAX : lock_cnt_reg + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      sync_reg        <= '0;
      chop_reg        <= 1'b0;
      fine_reg        <= 8'h80;
      lock_cnt_reg    <= '0;
      prev_up_reg     <= 1'b0;
      prev_valid_reg  <= 1'b0;
      locked_reg      <= 1'b0;
      idacCoarse      <= '0;
      resStableSelect <= 1'b0;
      pwrup           <= 1'b0;
      resPtatEnable_n <= 1'b1;
      idacOutSelect_n <= 4'hF;
      busy            <= 1'b0;
      diodeSelect     <= 8'h00;
      c1              <= 2'b00;
      c2              <= 2'b00;
      cmpZeroOffset   <= 1'b0;
    end else begin
      sync_reg        <= {sync_reg[0], cmpo};
      idacCoarse      <= idacCoarseCfg;
      resStableSelect <= resStableCfg;
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;

      // Outputs are decoded from the next state so they line up with it.
      pwrup           <= (state_next != ST_IDLE);
      busy            <= (state_next != ST_IDLE);
      resPtatEnable_n <= (state_next == ST_IDLE);
      idacOutSelect_n <= (state_next == ST_IDLE) ? 4'b1111 : 4'b1100;
      cmpZeroOffset   <= (state_next == ST_ZERO);
      c1              <= (state_next == ST_SAMPLE_A) ? 2'b11 : 2'b00;
      c2              <= (state_next == ST_SAMPLE_B) ? 2'b11 : 2'b00;
      case (state_next)
        ST_SAMPLE_A, ST_HOLD_A: diodeSelect <= 8'h01;
        ST_SAMPLE_B, ST_HOLD_B: diodeSelect <= 8'hFF;
        default:                diodeSelect <= 8'h00;
      endcase

      if (abort) begin
        // Dropping out keeps the trimmed code but forgets loop history.
        chop_reg       <= 1'b0;
        lock_cnt_reg   <= '0;
        prev_valid_reg <= 1'b0;
        locked_reg     <= 1'b0;
      end else begin
        if (cmp_done) begin
          if (!blocked)
            fine_reg <= up ? fine_reg + 8'd1 : fine_reg - 8'd1;
          prev_up_reg    <= up;
          prev_valid_reg <= 1'b1;
          lock_cnt_reg   <= lock_cnt_next;
          locked_reg     <= (lock_cnt_next == LOCK_MAX);
        end
        // Chop flips when leaving UPDATE so the next loop uses swapped inputs.
        if (state_reg == ST_UPDATE)
          chop_reg <= ~chop_reg;
      end
    end
  end

  assign idacFine     = fine_reg;
  assign cmpSwapInput = chop_reg;
  assign locked       = locked_reg;

endmodule

// File: tb/tb_bg_ctrl.sv
// tb_bg_ctrl -- scoreboard bench for bg_ctrl.
// The reference model tracks time since start and derives the phase from
// offsets within the measurement loop; expected outputs are queued every
// cycle and a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_bg_ctrl;
  localparam int S  = 16;
  localparam int C  = 4;
  localparam int LK = 8;
  localparam int L  = 2 * S + C + 3;

  localparam int PH_IDLE = 0, PH_PWRUP = 1, PH_ZERO = 2, PH_SA = 3, PH_HA = 4,
                 PH_SB = 5, PH_HB = 6, PH_CMP = 7, PH_UPD = 8;

  logic       clk, reset, enable, resStableCfg, cmpo;
  logic [7:0] idacCoarseCfg;
  logic       pwrup, resStableSelect, resPtatEnable_n, cmpZeroOffset, cmpSwapInput, busy, locked;
  logic [7:0] idacFine, idacCoarse, diodeSelect;
  logic [3:0] idacOutSelect_n;
  logic [1:0] c1, c2;

  bg_ctrl #(.SETTLE_CYC(S), .CMP_CYC(C), .LOCK_COUNT(LK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .idacCoarseCfg(idacCoarseCfg),
    .resStableCfg(resStableCfg), .cmpo(cmpo), .pwrup(pwrup), .idacFine(idacFine),
    .idacCoarse(idacCoarse), .idacOutSelect_n(idacOutSelect_n), .diodeSelect(diodeSelect),
    .resStableSelect(resStableSelect), .resPtatEnable_n(resPtatEnable_n), .c1(c1), .c2(c2),
    .cmpZeroOffset(cmpZeroOffset), .cmpSwapInput(cmpSwapInput), .busy(busy), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         ph;
    logic       pwrup, ptat_n, busy, zero, swap, locked, res;
    logic [3:0] osel;
    logic [7:0] diode, fine, coarse;
    logic [1:0] c1, c2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mon_cyc = 0;
  bit   hist [0:32767];

  // Reference model state
  bit         m_running = 0;
  int         m_t = 0;
  logic [7:0] m_fine = 8'h80;
  logic [7:0] m_coarse = 8'h00;
  bit         m_res = 0, m_chop = 0, m_locked = 0, m_pv = 0, m_prev_up = 0, m_last_up = 0;
  int         m_streak = 0;

  // Stimulus controls
  bit drv_reset = 1, drv_enable = 0, cmpo_const = 0;
  int mode = 0;

  function automatic int phase_of(input int t);
    int u;
    if (t < S) return PH_PWRUP;
    if (t < S + C) return PH_ZERO;
    u = (t - S - C) % L;
    if (u < S) return PH_SA;
    if (u == S) return PH_HA;
    if (u < 2 * S + 1) return PH_SB;
    if (u == 2 * S + 1) return PH_HB;
    if (u < 2 * S + 2 + C) return PH_CMP;
    return PH_UPD;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cyc=%0d %s got=%h exp=%h", mon_cyc, name, got, exp);
    end
  endtask

  // Decision at the edge entering UPDATE: the comparator value seen then is
  // what was driven three cycles earlier (two sync flops plus the edge).
  task automatic model_decide();
    bit up, blk;
    up  = hist[cyc - 3] ^ m_chop;
    blk = up ? (m_fine == 8'hFF) : (m_fine == 8'h00);
    if (!blk) m_fine = up ? m_fine + 8'd1 : m_fine - 8'd1;
    if (!m_pv || blk || up == m_prev_up) m_streak = 0;
    else m_streak = (m_streak + 1 > LK) ? LK : m_streak + 1;
    m_prev_up = up;
    m_last_up = up;
    m_pv = 1;
    m_locked = (m_streak == LK);
  endtask

  task automatic model_advance();
    if (reset) begin
      m_running = 0; m_fine = 8'h80; m_coarse = 8'h00; m_res = 0;
      m_chop = 0; m_streak = 0; m_locked = 0; m_pv = 0;
    end else begin
      m_coarse = idacCoarseCfg;
      m_res    = resStableCfg;
      if (m_running && !enable) begin
        m_running = 0; m_streak = 0; m_locked = 0; m_chop = 0; m_pv = 0;
      end else if (!m_running) begin
        if (enable) begin
          m_running = 1;
          m_t = 0;
        end
      end else begin
        if (phase_of(m_t) == PH_UPD) m_chop = ~m_chop;
        m_t++;
        if (phase_of(m_t) == PH_UPD) model_decide();
      end
    end
  endtask

  task automatic step();
    exp_t e;
    int   ph;
    @(posedge clk);
    #1;
    cyc++;
    model_advance();
    ph = m_running ? phase_of(m_t) : PH_IDLE;
    e.cyc    = cyc;
    e.ph     = ph;
    e.pwrup  = (ph != PH_IDLE);
    e.busy   = (ph != PH_IDLE);
    e.ptat_n = (ph == PH_IDLE);
    e.osel   = (ph == PH_IDLE) ? 4'hF : 4'hC;
    e.diode  = (ph == PH_SA || ph == PH_HA) ? 8'h01 : (ph == PH_SB || ph == PH_HB) ? 8'hFF : 8'h00;
    e.c1     = (ph == PH_SA) ? 2'b11 : 2'b00;
    e.c2     = (ph == PH_SB) ? 2'b11 : 2'b00;
    e.zero   = (ph == PH_ZERO);
    e.swap   = m_chop;
    e.fine   = m_fine;
    e.locked = m_locked;
    e.coarse = m_coarse;
    e.res    = m_res;
    exp_q.push_back(e);
    reset         = drv_reset;
    enable        = drv_enable;
    idacCoarseCfg = 8'($urandom);
    resStableCfg  = 1'($urandom);
    case (mode)
      0:       cmpo = cmpo_const;
      1:       cmpo = ~m_chop;
      2:       cmpo = ~m_last_up ^ m_chop;
      3:       cmpo = m_last_up ^ m_chop;
      default: cmpo = 1'($urandom);
    endcase
    hist[cyc] = cmpo;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_phase(input int ph);
    int g;
    g = 0;
    while (!(m_running && phase_of(m_t) == ph) && g < 4 * L) begin
      step();
      g++;
    end
    checks++;
    if (g >= 4 * L) begin
      errors++;
      $display("FAIL cyc=%0d phase_wait got=timeout exp=phase%0d", cyc, ph);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_cyc = e.cyc;
        chk("pwrup", 8'(pwrup), 8'(e.pwrup));
        chk("busy", 8'(busy), 8'(e.busy));
        chk("resPtatEnable_n", 8'(resPtatEnable_n), 8'(e.ptat_n));
        chk("idacOutSelect_n", 8'(idacOutSelect_n), 8'(e.osel));
        chk("diodeSelect", diodeSelect, e.diode);
        chk("c1", 8'(c1), 8'(e.c1));
        chk("c2", 8'(c2), 8'(e.c2));
        chk("cmpZeroOffset", 8'(cmpZeroOffset), 8'(e.zero));
        chk("cmpSwapInput", 8'(cmpSwapInput), 8'(e.swap));
        chk("idacFine", idacFine, e.fine);
        chk("locked", 8'(locked), 8'(e.locked));
        chk("idacCoarse", idacCoarse, e.coarse);
        chk("resStableSelect", 8'(resStableSelect), 8'(e.res));
        if (e.ph == PH_UPD)
          $display("update cyc=%0d idacFine=%02h exp=%02h locked=%0d swap=%0d",
                   e.cyc, idacFine, e.fine, locked, cmpSwapInput);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] saved_fine;
    int g;
    reset = 1; enable = 0; cmpo = 0; idacCoarseCfg = 8'h00; resStableCfg = 0;

    // Reset, then idle with enable low
    drv_reset = 1; run(3);
    drv_reset = 0; run(3);

    // Start with comparator held high
    drv_enable = 1; mode = 0; cmpo_const = 1;
    run(S + C + 5 * L);

    // Always step up: climb to the top code and stay there
    mode = 1;
    g = 0;
    while (m_fine != 8'hFF && g < 8000) begin
      step();
      g++;
    end
    run(4 * L);
    chk("sat_fine", idacFine, 8'hFF);
    chk("sat_locked", 8'(locked), 8'h00);

    // Alternating decisions acquire lock; one repeat drops it
    run_until_phase(PH_SA);
    mode = 2; run(12 * L);
    chk("lock_set", 8'(locked), 8'h01);
    mode = 3; run(L);
    chk("lock_drop", 8'(locked), 8'h00);
    mode = 2; run(10 * L);
    chk("lock_again", 8'(locked), 8'h01);

    // Drop enable during SAMPLE_B
    run_until_phase(PH_SB);
    saved_fine = m_fine;
    drv_enable = 0; run(2);
    chk("dis_busy", 8'(busy), 8'h00);
    chk("dis_c2", 8'(c2), 8'h00);
    chk("dis_diode", diodeSelect, 8'h00);
    chk("dis_locked", 8'(locked), 8'h00);
    chk("dis_fine", idacFine, saved_fine);
    drv_enable = 1; mode = 4; run(S + C + 2 * L);

    // Reset during COMPARE
    run_until_phase(PH_CMP);
    drv_reset = 1; run(2);
    chk("rst_fine", idacFine, 8'h80);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_osel", 8'(idacOutSelect_n), 8'h0F);
    chk("rst_coarse", idacCoarse, 8'h00);
    drv_reset = 0; run(S + C + 3 * L);

    // Random comparator, occasional enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      drv_enable = ($urandom_range(0, 199) != 0);
      drv_reset  = ($urandom_range(0, 1499) == 0);
      step();
    end
    drv_reset = 0; drv_enable = 0; run(3);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL cyc=%0d drain got=%0d exp=0", cyc, exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
